serial_result_packer: RTL
=========================

// Module: serial_result_packer
// PURPOSE
//  Downstream stage of the two-line serial flow comparator. Samples its per-cycle result bit
//  (outp) and overflow flag (overflw), packs bits LSB-first into W-bit words, and tags each
//  word with an overflow marker. Buffers words in a small FIFO and presents them on a
//  valid/ready interface to the result sink. Also keeps saturating event/drop counters.
// PARAMETERS
//  W      8  word width in bits (>=2)
//  DEPTH  4  FIFO depth in words (power of 2, >=2)
//  CW     8  width of the ovf_cnt and drop_cnt counters
// PORTS
//  clock      in   1          clock; all logic on the rising edge
//  reset      in   1          reset, synchronous, active-high
//  bit_in     in   1          result bit from the comparator (outp)
//  ovf_in     in   1          overflow flag from the comparator (overflw)
//  bit_vld    in   1          bit_in/ovf_in valid this cycle (tie 1 for free-running)
//  flush      in   1          push a partial word now (1-cycle pulse)
//  out_valid  out  1          FIFO head valid
//  out_ready  in   1          sink accepts the head word
//  out_data   out  W          packed word; the first sampled bit is in bit 0
//  out_len    out  $clog2(W+1) number of valid bits in out_data (W for a full word)
//  out_ovf    out  1          OR of ovf_in over the bits in this word
//  ovf_cnt    out  CW         saturating count of sampled cycles with ovf_in=1
//  drop_cnt   out  CW         saturating count of words dropped because the FIFO was full
// BEHAVIOUR
//  - Reset: out_valid=0, ovf_cnt=0, drop_cnt=0, FIFO empty, bit count=0, state IDLE.
//    out_data, out_len and out_ovf read 0 while empty.
//  - FSM (shared enum): IDLE -> FILL on the first bit_vld; FILL -> IDLE when a word is
//    pushed and no new bit is sampled in the same cycle.
//  - Sampling: with bit_vld=1, bit_in goes to shreg[cnt], cnt++, and ovf_in is ORed into
//    word_ovf. ovf_cnt increments when bit_vld&ovf_in, holding at 2^CW-1.
//  - Full word: the cycle that samples bit W-1 pushes {shreg, len=W, word_ovf}. cnt, shreg
//    and word_ovf clear. out_valid rises the next cycle when the FIFO was empty.
//    Latency from last bit to out_valid is 1 clock.
//  - flush with cnt>0: push a partial word zero-padded above bit cnt-1, with len=cnt.
//    flush with cnt=0 is ignored.
//  - flush and bit_vld together: the bit is sampled first, then the word (len=cnt+1) is
//    pushed. If that bit completes the word, only one push happens (len=W).
//  - Handshake: the head pops when out_valid&out_ready. Head fields are stable while
//    out_valid=1 and out_ready=0. out_valid never drops without a pop.
//  - Full FIFO: a push is accepted if a pop happens in the same cycle. Otherwise the word
//    is dropped, drop_cnt increments (saturating), and the packer still clears and goes on.
//  - Pointers wrap modulo DEPTH. Full/empty are distinguished with an extra pointer bit.
//  - Reset mid-word or with the FIFO non-empty discards all contents. No output is
//    generated by the reset.
// CONFIGURATION
//  PACKER_PARITY_EN defined: adds output port out_par (1 bit) = ^out_data of the head
//    word. It is stored per FIFO entry and reads 0 when empty.
//  PACKER_PARITY_EN undefined: the out_par port and its storage are absent; all other
//    behaviour is identical.
// STRUCTURE
//  - serial_cmp_pkg holds:
//    - the packer_state_t enum {IDLE, FILL}
//    - the FIFO entry struct {data, len, ovf[, par]}
//    - the localparam for len width
//    The comparator state codes also live there.
//  - Sub-module result_fifo holds the synchronous FIFO (DEPTH, entry type, push/pop,
//    full/empty, push-on-full-with-pop). The top holds the packer FSM and counters.
// TESTING (W=8, DEPTH=4, CW=8)
//  1. bit_vld=1, 8 bits 1,0,1,1,0,0,1,0, ovf_in=0, out_ready=1 -> one word out_data=8'h4D,
//     out_len=8, out_ovf=0, out_valid 1 clock after bit 8.
//  2. 3 bits 1,1,0 then flush -> out_data=8'h03, out_len=3.
//     A flush with no pending bits -> no word.
//  3. ovf_in=1 on bit 5 only -> that word has out_ovf=1, the next word has 0; ovf_cnt=1.
//  4. out_ready=0, push 6 full words -> 4 held, drop_cnt=2.
//     Then drain -> words in order, fields stable while stalled.
//  5. FIFO full, out_ready=1 on the cycle a 5th word completes -> accepted, drop_cnt=0.
//  6. reset after 5 bits with 2 words queued -> out_valid=0 next cycle, counters 0.
//     The next 8 bits form a fresh word.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared types for the two-line serial flow comparator and its result packer.
// Optional feature macro: PACKER_PARITY_EN (adds a parity bit to each FIFO entry).
package serial_cmp_pkg;

    // Word width the FIFO entry is sized for; the packer's W must match it.
    localparam int PACK_W = 8;
    // Width needed to hold a bit count from 0 to PACK_W inclusive.
    localparam int LEN_W  = $clog2(PACK_W + 1);

    // Comparator state codes.
    typedef enum logic [1:0] {
        CMP_IDLE,
        CMP_LOAD,
        CMP_COMPARE,
        CMP_DONE
    } cmp_state_t;

    // Packer FSM states.
    typedef enum logic {
        IDLE,
        FILL
    } packer_state_t;

    // One buffered result word.
    typedef struct packed {
        logic [PACK_W-1:0] data;
        logic [LEN_W-1:0]  len;
        logic              ovf;
`ifdef PACKER_PARITY_EN
        logic              par;
`endif
    } pack_entry_t;

endpackage

// File: rtl/serial_result_packer_if.sv
// Valid/ready result bus between the packer and the result sink.
// Optional feature macro: PACKER_PARITY_EN (adds out_par).
interface serial_result_packer_if import serial_cmp_pkg::*; #(
    parameter int W    = PACK_W,
    parameter int LW   = LEN_W
);
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [LW-1:0] out_len;
    logic          out_ovf;
`ifdef PACKER_PARITY_EN
    logic          out_par;
`endif

    modport master (
`ifdef PACKER_PARITY_EN
        output out_par,
`endif
        output out_valid,
        output out_data,
        output out_len,
        output out_ovf,
        input  out_ready
    );

    modport slave (
`ifdef PACKER_PARITY_EN
        input  out_par,
`endif
        input  out_valid,
        input  out_data,
        input  out_len,
        input  out_ovf,
        output out_ready
    );

endinterface

// File: rtl/result_fifo.sv
// Synchronous word FIFO for the result packer. A push while full is accepted
// only when a pop happens in the same cycle. Head reads zero while empty.
// Optional feature macro: PACKER_PARITY_EN (entry carries a parity bit).
module result_fifo import serial_cmp_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  pack_entry_t push_data,
    input  logic        pop,
    output pack_entry_t head,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    pack_entry_t mem_q [DEPTH];
    pack_entry_t mem_d [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Next storage and pointer values for the accepted push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only visible through head while non-empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/serial_result_packer.sv
// Packs the comparator's per-cycle result bits LSB-first into words tagged with
// an overflow marker, buffers them and offers them on a valid/ready bus.
// Optional feature macro: PACKER_PARITY_EN (adds out_par on the result bus).
module serial_result_packer import serial_cmp_pkg::*; #(
    parameter int W     = PACK_W,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   bit_in,
    input  logic                   ovf_in,
    input  logic                   bit_vld,
    input  logic                   flush,
    serial_result_packer_if.master out_if,
    output logic [CW-1:0]          ovf_cnt,
    output logic [CW-1:0]          drop_cnt
);
    localparam int               IDX_W    = $clog2(W);
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(W - 1);

    packer_state_t    state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [W-1:0]     shreg_q, shreg_d, shreg_s;
    logic             word_ovf_q, word_ovf_d, word_ovf_s;
    logic [CW-1:0]    ovf_cnt_q, ovf_cnt_d;
    logic [CW-1:0]    drop_cnt_q, drop_cnt_d;
    logic             full_word;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;
    pack_entry_t      push_entry;
    pack_entry_t      head_entry;

    // State and word-assembly registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            word_ovf_q <= 1'b0;
            ovf_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            word_ovf_q <= word_ovf_d;
            ovf_cnt_q  <= ovf_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Next FSM state: start filling on the first bit, idle after a flush-only push.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bit_vld) state_d = FILL;
            FILL:    if (push && !bit_vld) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sample this cycle's bit first, then decide whether a word leaves the packer.
    always_comb begin
        shreg_s = shreg_q;
        if (bit_vld) begin
            shreg_s[cnt_q[IDX_W-1:0]] = bit_in;
        end
        word_ovf_s = word_ovf_q | (bit_vld & ovf_in);
        cnt_inc    = bit_vld ? cnt_q + 1'b1 : cnt_q;
        full_word  = bit_vld && (cnt_q == LAST_IDX);
        push       = full_word || (flush && (cnt_inc != '0));

        push_entry      = '0;
        push_entry.data = shreg_s;
        push_entry.len  = cnt_inc;
        push_entry.ovf  = word_ovf_s;
`ifdef PACKER_PARITY_EN
        push_entry.par  = ^shreg_s;
`endif

        if (push) begin
            cnt_d      = '0;
            shreg_d    = '0;
            word_ovf_d = 1'b0;
        end else begin
            cnt_d      = cnt_inc;
            shreg_d    = shreg_s;
            word_ovf_d = word_ovf_s;
        end
    end

    // Saturating counters for overflow samples and words lost to a full FIFO.
    always_comb begin
        ovf_cnt_d  = ovf_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (bit_vld && ovf_in && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
        if (push && fifo_full && !out_if.out_ready && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (out_if.out_ready),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_if.out_valid = ~fifo_empty;
    assign out_if.out_data  = head_entry.data;
    assign out_if.out_len   = head_entry.len;
    assign out_if.out_ovf   = head_entry.ovf;
`ifdef PACKER_PARITY_EN
    assign out_if.out_par   = head_entry.par;
`endif
    assign ovf_cnt          = ovf_cnt_q;
    assign drop_cnt         = drop_cnt_q;

endmodule
